// File: rtl/rs_control_seq.sv
// Sequenced control unit for the relatively-simple CPU: fetch/decode/execute FSM with
// per-byte operand fetch, branch skip and memory wait handshake driving the datapath strobes.
module rs_control_seq #(
   parameter int ADDR_BYTES = 2,
   parameter int NREG       = 1,
   parameter int RSW        = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic           CLK,
   input  logic           CLEAR,
   input  logic [7:0]     IR,
   input  logic           Z,
   input  logic           MEM_READY,
   output logic           PC_RESET,
   output logic           AC_CLR,
   output logic           AR_LOAD,
   output logic           AR_INC,
   output logic           PC_BUS,
   output logic           PC_LOAD,
   output logic           PC_INC,
   output logic           DR_LOAD,
   output logic           DR_BUS,
   output logic           ADDR_SHIFT,
   output logic           TR_BUS,
   output logic           IR_LOAD,
   output logic           R_BUS,
   output logic           R_LOAD,
   output logic           AC_BUS,
   output logic           AC_LOAD,
   output logic           MEM_RD,
   output logic           MEM_WR,
   output logic [RSW-1:0] R_SEL,
   output logic [3:0]     ALU_OP,
   output logic [3:0]     STATE
);

   typedef enum logic [3:0] {
      FETCH1 = 4'd0,
      FETCH2 = 4'd1,
      FETCH3 = 4'd2,
      DECODE = 4'd3,
      ADRD   = 4'd4,
      ADSH   = 4'd5,
      SKIP   = 4'd6,
      ADAR   = 4'd7,
      DRD    = 4'd8,
      DWB    = 4'd9,
      DWR    = 4'd10,
      JMP    = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDAC = 4'h1;
   localparam logic [3:0] OP_STAC = 4'h2;
   localparam logic [3:0] OP_MVAC = 4'h3;
   localparam logic [3:0] OP_MOVR = 4'h4;
   localparam logic [3:0] OP_JUMP = 4'h5;
   localparam logic [3:0] OP_JMPZ = 4'h6;
   localparam logic [3:0] OP_JPNZ = 4'h7;
   localparam logic [3:0] OP_ADD  = 4'h8;
   localparam logic [3:0] OP_SUB  = 4'h9;
   localparam logic [3:0] OP_INAC = 4'hA;
   localparam logic [3:0] OP_CLAC = 4'hB;
   localparam logic [3:0] OP_AND  = 4'hC;
   localparam logic [3:0] OP_OR   = 4'hD;
   localparam logic [3:0] OP_XOR  = 4'hE;
   localparam logic [3:0] OP_NOT  = 4'hF;

   localparam logic [2:0] CNT_LAST = 3'(ADDR_BYTES - 1);

   state_t     state;
   logic [2:0] cnt;
   logic [3:0] opcode;

   assign opcode = IR[7:4];

   // Register indices beyond the implemented file wrap around modulo NREG.
   function automatic logic [RSW-1:0] alias_reg(input logic [3:0] idx);
      return RSW'(int'(idx) % NREG);
   endfunction

   // Byte counter serves both the operand-address fetch loop and the skip dwell.
   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         state <= FETCH1;
         cnt   <= '0;
      end else begin
         case (state)
            FETCH1: state <= FETCH2;
            FETCH2: if (MEM_READY) state <= FETCH3;
            FETCH3: begin
               state <= DECODE;
               cnt   <= '0;
            end
            DECODE: begin
               case (opcode)
                  OP_LDAC, OP_STAC, OP_JUMP: state <= ADRD;
                  OP_JMPZ:                   state <= Z ? ADRD : SKIP;
                  OP_JPNZ:                   state <= Z ? SKIP : ADRD;
                  default:                   state <= FETCH1;
               endcase
            end
            ADRD: if (MEM_READY) state <= ADSH;
            ADSH: begin
               cnt <= cnt + 3'd1;
               if (cnt < CNT_LAST)
                  state <= ADRD;
               else if (opcode == OP_LDAC || opcode == OP_STAC)
                  state <= ADAR;
               else
                  state <= JMP;
            end
            SKIP: begin
               if (cnt == CNT_LAST)
                  state <= FETCH1;
               else
                  cnt <= cnt + 3'd1;
            end
            ADAR: begin
               if (opcode == OP_LDAC)
                  state <= DRD;
               else if (opcode == OP_STAC)
                  state <= DWR;
               else
                  state <= FETCH1;
            end
            DRD:     if (MEM_READY) state <= DWB;
            DWB:     state <= FETCH1;
            DWR:     if (MEM_READY) state <= FETCH1;
            JMP:     state <= FETCH1;
            default: state <= FETCH1;
         endcase
      end
   end

   assign PC_RESET = CLEAR;
   assign AC_CLR   = CLEAR;
   assign STATE    = state;
   assign R_SEL    = CLEAR ? '0 : alias_reg(IR[3:0]);

   // Strobes decode the registered state; only the PC/AR increments look at MEM_READY.
   always_comb begin
      AR_LOAD    = 1'b0;
      AR_INC     = 1'b0;
      PC_BUS     = 1'b0;
      PC_LOAD    = 1'b0;
      PC_INC     = 1'b0;
      DR_LOAD    = 1'b0;
      DR_BUS     = 1'b0;
      ADDR_SHIFT = 1'b0;
      TR_BUS     = 1'b0;
      IR_LOAD    = 1'b0;
      R_BUS      = 1'b0;
      R_LOAD     = 1'b0;
      AC_BUS     = 1'b0;
      AC_LOAD    = 1'b0;
      MEM_RD     = 1'b0;
      MEM_WR     = 1'b0;
      ALU_OP     = 4'd0;
      if (!CLEAR) begin
         case (state)
            FETCH1: begin
               PC_BUS  = 1'b1;
               AR_LOAD = 1'b1;
            end
            FETCH2: begin
               MEM_RD  = 1'b1;
               DR_LOAD = 1'b1;
               PC_INC  = MEM_READY;
            end
            FETCH3: begin
               IR_LOAD = 1'b1;
               PC_BUS  = 1'b1;
               AR_LOAD = 1'b1;
            end
            DECODE: begin
               case (opcode)
                  OP_MVAC: begin
                     AC_BUS = 1'b1;
                     R_LOAD = 1'b1;
                  end
                  OP_MOVR: begin
                     R_BUS   = 1'b1;
                     AC_LOAD = 1'b1;
                  end
                  OP_ADD:  begin AC_LOAD = 1'b1; R_BUS = 1'b1; ALU_OP = 4'd1; end
                  OP_SUB:  begin AC_LOAD = 1'b1; R_BUS = 1'b1; ALU_OP = 4'd2; end
                  OP_INAC: begin AC_LOAD = 1'b1; ALU_OP = 4'd3; end
                  OP_CLAC: begin AC_LOAD = 1'b1; ALU_OP = 4'd4; end
                  OP_AND:  begin AC_LOAD = 1'b1; R_BUS = 1'b1; ALU_OP = 4'd5; end
                  OP_OR:   begin AC_LOAD = 1'b1; R_BUS = 1'b1; ALU_OP = 4'd6; end
                  OP_XOR:  begin AC_LOAD = 1'b1; R_BUS = 1'b1; ALU_OP = 4'd7; end
                  OP_NOT:  begin AC_LOAD = 1'b1; ALU_OP = 4'd8; end
                  default: ALU_OP = 4'd0;
               endcase
            end
            ADRD: begin
               MEM_RD  = 1'b1;
               DR_LOAD = 1'b1;
               PC_INC  = MEM_READY;
               AR_INC  = MEM_READY;
            end
            ADSH: ADDR_SHIFT = 1'b1;
            SKIP: PC_INC = 1'b1;
            ADAR: begin
               TR_BUS  = 1'b1;
               AR_LOAD = 1'b1;
            end
            DRD: begin
               MEM_RD  = 1'b1;
               DR_LOAD = 1'b1;
            end
            DWB: begin
               DR_BUS  = 1'b1;
               AC_LOAD = 1'b1;
            end
            DWR: begin
               AC_BUS = 1'b1;
               MEM_WR = 1'b1;
            end
            JMP: begin
               TR_BUS  = 1'b1;
               PC_LOAD = 1'b1;
            end
            default: AR_LOAD = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_control_seq.sv
// Directed bench for rs_control_seq: a 2-byte/4-register main instance plus 1-byte and
// 4-byte address variants run side by side for the operand-length regressions.
module tb_rs_control_seq;

   localparam logic [3:0] S_FETCH1 = 4'd0;
   localparam logic [3:0] S_FETCH2 = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd3;
   localparam logic [3:0] S_DRD    = 4'd8;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [7:0] ir = 8'h00;
   logic       z = 1'b0;
   logic       mem_ready = 1'b1;

   int total = 0;
   int bad   = 0;

   wire pc_reset, ac_clr, ar_load, ar_inc, pc_bus, pc_load, pc_inc, dr_load, dr_bus;
   wire addr_shift, tr_bus, ir_load, r_bus, r_load, ac_bus, ac_load, mem_rd, mem_wr;
   wire [1:0] r_sel;
   wire [3:0] alu_op, state;

   // Variant strobe order: AR_LOAD..MEM_WR in port order at bits 0..15.
   wire [15:0] sb1, sb4;
   wire        pr1, ac1, pr4, ac4;
   wire [0:0]  rs1, rs4;
   wire [3:0]  alu1, alu4, st1, st4;

   typedef struct {
      int ret; int pcload_at; int trbus_at_load; int shifts; int adrd; int arinc;
      int pcinc_late; int memwr; int acbus; int writes; int first_wr; int dwb_at;
   } trace_t;

   logic [17:0] dec_tab [0:10] = '{
      {8'h83, 4'd1, 4'b1001, 2'd3}, {8'hF0, 4'd8, 4'b0001, 2'd0},
      {8'h37, 4'd0, 4'b0110, 2'd3}, {8'h4A, 4'd0, 4'b1001, 2'd2},
      {8'hA1, 4'd3, 4'b0001, 2'd1}, {8'h96, 4'd2, 4'b1001, 2'd2},
      {8'hD5, 4'd6, 4'b1001, 2'd1}, {8'hB0, 4'd4, 4'b0001, 2'd0},
      {8'hC2, 4'd5, 4'b1001, 2'd2}, {8'hE3, 4'd7, 4'b1001, 2'd3},
      {8'h00, 4'd0, 4'b0000, 2'd0}
   };

   always #5 clk = ~clk;

   rs_control_seq #(.ADDR_BYTES(2), .NREG(4)) dut (
      .CLK(clk), .CLEAR(clear), .IR(ir), .Z(z), .MEM_READY(mem_ready),
      .PC_RESET(pc_reset), .AC_CLR(ac_clr), .AR_LOAD(ar_load), .AR_INC(ar_inc),
      .PC_BUS(pc_bus), .PC_LOAD(pc_load), .PC_INC(pc_inc), .DR_LOAD(dr_load),
      .DR_BUS(dr_bus), .ADDR_SHIFT(addr_shift), .TR_BUS(tr_bus), .IR_LOAD(ir_load),
      .R_BUS(r_bus), .R_LOAD(r_load), .AC_BUS(ac_bus), .AC_LOAD(ac_load),
      .MEM_RD(mem_rd), .MEM_WR(mem_wr), .R_SEL(r_sel), .ALU_OP(alu_op), .STATE(state)
   );

   rs_control_seq #(.ADDR_BYTES(1), .NREG(1)) dut_a1 (
      .CLK(clk), .CLEAR(clear), .IR(ir), .Z(z), .MEM_READY(mem_ready),
      .PC_RESET(pr1), .AC_CLR(ac1), .AR_LOAD(sb1[0]), .AR_INC(sb1[1]),
      .PC_BUS(sb1[2]), .PC_LOAD(sb1[3]), .PC_INC(sb1[4]), .DR_LOAD(sb1[5]),
      .DR_BUS(sb1[6]), .ADDR_SHIFT(sb1[7]), .TR_BUS(sb1[8]), .IR_LOAD(sb1[9]),
      .R_BUS(sb1[10]), .R_LOAD(sb1[11]), .AC_BUS(sb1[12]), .AC_LOAD(sb1[13]),
      .MEM_RD(sb1[14]), .MEM_WR(sb1[15]), .R_SEL(rs1), .ALU_OP(alu1), .STATE(st1)
   );

   rs_control_seq #(.ADDR_BYTES(4), .NREG(1)) dut_a4 (
      .CLK(clk), .CLEAR(clear), .IR(ir), .Z(z), .MEM_READY(mem_ready),
      .PC_RESET(pr4), .AC_CLR(ac4), .AR_LOAD(sb4[0]), .AR_INC(sb4[1]),
      .PC_BUS(sb4[2]), .PC_LOAD(sb4[3]), .PC_INC(sb4[4]), .DR_LOAD(sb4[5]),
      .DR_BUS(sb4[6]), .ADDR_SHIFT(sb4[7]), .TR_BUS(sb4[8]), .IR_LOAD(sb4[9]),
      .R_BUS(sb4[10]), .R_LOAD(sb4[11]), .AC_BUS(sb4[12]), .AC_LOAD(sb4[13]),
      .MEM_RD(sb4[14]), .MEM_WR(sb4[15]), .R_SEL(rs4), .ALU_OP(alu4), .STATE(st4)
   );

   // Leaves the bench on a falling edge with the DUT sitting in FETCH1 (offset 0).
   task automatic do_reset();
      clear = 1'b1;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      clear = 1'b0;
   endtask

   // Runs one instruction on the main instance; MEM_READY is low for offsets lo_from..lo_to.
   task automatic trace_instr(input logic [7:0] op, input logic zv, input bit zflip,
                              input int lo_from, input int lo_to, output trace_t t);
      t = '{default: 0};
      t.ret = -1; t.pcload_at = -1; t.first_wr = -1; t.dwb_at = -1;
      ir = op;
      z = zv;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         mem_ready = (c >= lo_from && c <= lo_to) ? 1'b0 : 1'b1;
         if (zflip && c >= 4) z = ~zv;
         #1;
         if (pc_load && t.pcload_at < 0) begin
            t.pcload_at = c;
            t.trbus_at_load = int'(tr_bus);
         end
         if (addr_shift) t.shifts++;
         if (ar_inc) t.arinc++;
         if (c > 2 && mem_rd) t.adrd++;
         if (c > 2 && pc_inc) t.pcinc_late++;
         if (mem_wr) begin
            t.memwr++;
            if (t.first_wr < 0) t.first_wr = c;
            if (mem_ready) t.writes++;
         end
         if (ac_bus) t.acbus++;
         if (dr_bus && t.dwb_at < 0) t.dwb_at = c;
         if (c > 0 && state == S_FETCH1) begin
            t.ret = c;
            break;
         end
         @(negedge clk);
      end
      z = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      ir = 8'hFF;
      z = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({ar_load, ar_inc, pc_bus, pc_load, pc_inc, dr_load, dr_bus, addr_shift, tr_bus, ir_load,
           r_bus, r_load, ac_bus, ac_load, mem_rd, mem_wr, r_sel, alu_op} !== 22'd0) begin
         bad++; $display("FAIL reset_strobes got nonzero strobe set want all zero");
      end
      total++;
      if ({pc_reset, ac_clr} !== 2'b11) begin
         bad++; $display("FAIL reset_clears got=%b want=11", {pc_reset, ac_clr});
      end
      total++;
      if (state !== S_FETCH1) begin
         bad++; $display("FAIL reset_state got=%0d want=%0d", state, S_FETCH1);
      end
      total++;
      if ({sb1, sb4, rs1, rs4, alu1, alu4, pr1, ac1, pr4, ac4} !== {42'd0, 4'b1111}) begin
         bad++; $display("FAIL reset_variants sb1=%h sb4=%h clears=%b%b%b%b", sb1, sb4, pr1, ac1, pr4, ac4);
      end
      @(negedge clk);
      clear = 1'b0;
      #1;
      total++;
      if ({state, pc_bus, ar_load, pc_reset, ac_clr} !== {S_FETCH1, 4'b1100}) begin
         bad++; $display("FAIL reset_release got st=%0d pb=%b al=%b pr=%b ac=%b want st=0 1100",
                         state, pc_bus, ar_load, pc_reset, ac_clr);
      end
      @(negedge clk);
      #1;
      total++;
      if ({state, mem_rd, dr_load, pc_inc} !== {S_FETCH2, 3'b111}) begin
         bad++; $display("FAIL reset_fetch2 got st=%0d rd=%b dl=%b pi=%b want st=1 111",
                         state, mem_rd, dr_load, pc_inc);
      end
   endtask

   task automatic test_jump();
      trace_t t;
      trace_instr(8'h50, 1'b0, 1'b0, 99, 99, t);
      total++;
      if (t.pcload_at !== 8) begin bad++; $display("FAIL jump_pcload_at got=%0d want=8", t.pcload_at); end
      total++;
      if (t.trbus_at_load !== 1) begin bad++; $display("FAIL jump_trbus got=%0d want=1", t.trbus_at_load); end
      total++;
      if ({t.shifts, t.adrd, t.arinc} !== {32'd2, 32'd2, 32'd2}) begin
         bad++; $display("FAIL jump_bytes got shifts=%0d adrd=%0d arinc=%0d want 2 2 2", t.shifts, t.adrd, t.arinc);
      end
      total++;
      if (t.ret !== 9) begin bad++; $display("FAIL jump_ret got=%0d want=9", t.ret); end
   endtask

   task automatic test_branch();
      trace_t t;
      trace_instr(8'h60, 1'b0, 1'b0, 99, 99, t);
      total++;
      if ({t.ret, t.pcinc_late, t.adrd, t.pcload_at} !== {32'd6, 32'd2, 32'd0, -32'sd1}) begin
         bad++; $display("FAIL jmpz_skip got ret=%0d pcinc=%0d rd=%0d load=%0d want 6 2 0 -1",
                         t.ret, t.pcinc_late, t.adrd, t.pcload_at);
      end
      trace_instr(8'h60, 1'b1, 1'b1, 99, 99, t);
      total++;
      if ({t.pcload_at, t.shifts, t.ret} !== {32'd8, 32'd2, 32'd9}) begin
         bad++; $display("FAIL jmpz_taken got load=%0d shifts=%0d ret=%0d want 8 2 9",
                         t.pcload_at, t.shifts, t.ret);
      end
      trace_instr(8'h70, 1'b1, 1'b0, 99, 99, t);
      total++;
      if ({t.ret, t.pcinc_late, t.pcload_at} !== {32'd6, 32'd2, -32'sd1}) begin
         bad++; $display("FAIL jpnz_skip got ret=%0d pcinc=%0d load=%0d want 6 2 -1",
                         t.ret, t.pcinc_late, t.pcload_at);
      end
      trace_instr(8'h70, 1'b0, 1'b0, 99, 99, t);
      total++;
      if (t.pcload_at !== 8) begin bad++; $display("FAIL jpnz_taken got=%0d want=8", t.pcload_at); end
   endtask

   task automatic test_stac_wait();
      trace_t t;
      trace_instr(8'h20, 1'b0, 1'b0, 9, 11, t);
      total++;
      if (t.first_wr !== 9) begin bad++; $display("FAIL stac_first_wr got=%0d want=9", t.first_wr); end
      total++;
      if ({t.memwr, t.acbus} !== {32'd4, 32'd4}) begin
         bad++; $display("FAIL stac_hold got wr=%0d acbus=%0d want 4 4", t.memwr, t.acbus);
      end
      total++;
      if (t.writes !== 1) begin bad++; $display("FAIL stac_writes got=%0d want=1", t.writes); end
      total++;
      if (t.ret !== 13) begin bad++; $display("FAIL stac_ret got=%0d want=13", t.ret); end
      trace_instr(8'h10, 1'b0, 1'b0, 99, 99, t);
      total++;
      if ({t.dwb_at, t.ret, t.memwr} !== {32'd10, 32'd11, 32'd0}) begin
         bad++; $display("FAIL ldac_main got dwb=%0d ret=%0d wr=%0d want 10 11 0", t.dwb_at, t.ret, t.memwr);
      end
   endtask

   task automatic test_reg_alu();
      logic [17:0] e;
      for (int i = 0; i < 11; i++) begin
         e = dec_tab[i];
         ir = e[17:10];
         do_reset();
         repeat (3) @(negedge clk);
         #1;
         total++;
         if ({state, alu_op, r_bus, r_load, ac_bus, ac_load, r_sel} !== {S_DECODE, e[9:0]}) begin
            bad++; $display("FAIL decode_%h got st=%0d bits=%b want st=3 bits=%b", e[17:10], state,
                            {alu_op, r_bus, r_load, ac_bus, ac_load, r_sel}, e[9:0]);
         end
         @(negedge clk);
         #1;
         total++;
         if (state !== S_FETCH1) begin
            bad++; $display("FAIL decode_%h_ret got=%0d want=%0d", e[17:10], state, S_FETCH1);
         end
      end
   endtask

   task automatic test_clear_mid();
      int wr_seen = 0;
      int st_at9 = -1;
      ir = 8'h10;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         mem_ready = (c >= 9) ? 1'b0 : 1'b1;
         #1;
         if (mem_wr) wr_seen++;
         if (c == 9) st_at9 = int'(state);
         if (c < 9) @(negedge clk);
      end
      total++;
      if (st_at9 !== int'(S_DRD)) begin bad++; $display("FAIL clear_pre_drd got=%0d want=%0d", st_at9, S_DRD); end
      @(negedge clk);
      clear = 1'b1;
      #1;
      total++;
      if ({state, pc_reset, ac_clr, mem_wr, mem_rd} !== {S_FETCH1, 4'b1100}) begin
         bad++; $display("FAIL clear_async got st=%0d pr=%b ac=%b wr=%b rd=%b want st=0 1100",
                         state, pc_reset, ac_clr, mem_wr, mem_rd);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      if (mem_wr) wr_seen++;
      @(negedge clk);
      clear = 1'b0;
      #1;
      if (mem_wr) wr_seen++;
      total++;
      if ({state, pc_bus, pc_reset} !== {S_FETCH1, 2'b10}) begin
         bad++; $display("FAIL clear_release got st=%0d pb=%b pr=%b want st=0 10", state, pc_bus, pc_reset);
      end
      total++;
      if (wr_seen !== 0) begin bad++; $display("FAIL clear_no_write got=%0d want=0", wr_seen); end
   endtask

   task automatic test_addr_bytes();
      int sh1 = 0, sh4 = 0, dwb1 = -1, dwb4 = -1;
      bit done1 = 0, done4 = 0;
      ir = 8'h10;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         #1;
         if (!done1) begin
            if (sb1[7]) sh1++;
            if (sb1[6] && dwb1 < 0) dwb1 = c;
            if (c > 0 && st1 == S_FETCH1) done1 = 1;
         end
         if (!done4) begin
            if (sb4[7]) sh4++;
            if (sb4[6] && dwb4 < 0) dwb4 = c;
            if (c > 0 && st4 == S_FETCH1) done4 = 1;
         end
         if (done1 && done4) break;
         @(negedge clk);
      end
      total++;
      if ({dwb1, sh1} !== {32'd8, 32'd1}) begin
         bad++; $display("FAIL ldac_n1 got dwb=%0d shifts=%0d want 8 1", dwb1, sh1);
      end
      total++;
      if ({dwb4, sh4} !== {32'd14, 32'd4}) begin
         bad++; $display("FAIL ldac_n4 got dwb=%0d shifts=%0d want 14 4", dwb4, sh4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_jump();
      test_branch();
      test_stac_wait();
      test_reg_alu();
      test_clear_mid();
      test_addr_bytes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
